// File: rtl/tx_fifo_pkg.sv
// Shared sizing and types for the transmit FIFO controller.
// The FIFO sits between a host that pushes words and a serializer that
// shifts them out one frame at a time.
package tx_fifo_pkg;

    // Width of one transmit word.
    localparam int DATA_W = 12;

    // Number of storage entries; must be a power of two.
    localparam int DEPTH  = 16;

    // Pointer width: log2(DEPTH) index bits plus one wrap bit in the MSB.
    // The wrap bit is what tells "full" apart from "empty" when the
    // index bits are equal.
    localparam int PTR_W  = 5;

    // Frame-issue sequencer states.
    //   IDLE  : waiting for a word, permission and a free serializer
    //   START : tx_start_o is raised for this single cycle
    //   WAIT  : frame in flight, waiting for tx_done_i
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } tx_state_e;

    // Debug view of the controller, exported so checkers can bind to the
    // sequencer state and the per-cycle push/pop/drop decisions directly.
    typedef struct packed {
        tx_state_e state;
        logic      push;
        logic      pop;
        logic      drop;
    } tx_dbg_t;

endpackage : tx_fifo_pkg

// File: rtl/tx_fifo_mem.sv
// Register-file storage for the transmit FIFO: DEPTH x DATA_W entries,
// one synchronous write port and one asynchronous (combinational) read
// port. Contents are intentionally not reset; the pointers alone decide
// which entries hold valid data.
module tx_fifo_mem #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write one entry on each enabled rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read port is combinational so the word at the read pointer is
    // available in the same cycle the pop decision is made.
    assign rdata_o = mem_q[raddr_i];

endmodule : tx_fifo_mem

// File: rtl/transmit_fifo_ctrl.sv
// Transmit FIFO controller.
//
// The host pushes words with wr_en_i. Whenever the sequencer is idle,
// transmission is permitted (TXen_i), the FIFO holds a word and the
// serializer is not busy, one word is popped into the tx_data_o register
// and a single-cycle tx_start_o request is issued.
//
// Serializer handshake: tx_start_o is a one-cycle request; tx_data_o is
// valid from that cycle and held unchanged until the serializer answers
// with a one-cycle tx_done_i. No further start is issued before tx_done_i
// has been seen while waiting, and a tx_done_i arriving at any other time
// is ignored. tx_busy_i, while high, keeps a new frame from being started.
//
// fifo_en_i low flushes the FIFO (pointers and overflow flag) and parks
// the sequencer in IDLE; the last transmitted word stays on tx_data_o.
module transmit_fifo_ctrl
    import tx_fifo_pkg::*;
#(
    parameter int DATA_W = tx_fifo_pkg::DATA_W,
    parameter int DEPTH  = tx_fifo_pkg::DEPTH,
    parameter int PTR_W  = tx_fifo_pkg::PTR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fifo_en_i,
    input  logic              TXen_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              tx_busy_i,
    input  logic              tx_done_i,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [PTR_W-1:0]  tx_ptr_addr_wr_o,
    output logic [PTR_W-1:0]  tx_ptr_addr_rd_o,
    output logic [PTR_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o,
    output tx_dbg_t           dbg_o
);

    // Index bits of a pointer; the remaining MSB is the wrap bit.
    localparam int AW = PTR_W - 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    tx_state_e         state_q, state_d;

    // ------------------------------------------------------------------
    // Pointer decodes and per-cycle decisions
    // ------------------------------------------------------------------
    logic              empty;
    logic              full;
    logic              push;
    logic              drop;
    logic              pop;
    logic [DATA_W-1:0] rd_word;

    // Equal pointers mean empty; equal indexes with opposite wrap bits
    // mean the writer is exactly one lap ahead, i.e. full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);

    // Full is judged on the current pointers, so a push that meets a full
    // FIFO is dropped even if a pop frees an entry on the same edge.
    assign push = wr_en_i & fifo_en_i & ~full;
    assign drop = wr_en_i & fifo_en_i & full;

    // A word leaves only from IDLE, so at most one frame is ever in flight.
    assign pop  = fifo_en_i & (state_q == IDLE) & TXen_i & ~empty & ~tx_busy_i;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    tx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_word)
    );

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------

    // Advance pointers on push/pop, latch overflow on a dropped push,
    // and flush everything while the block is disabled.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (!fifo_en_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Capture the head word as it is popped; hold it for the whole frame
    // and across a flush.
    always_comb begin
        tx_data_d = tx_data_q;
        if (pop) begin
            tx_data_d = rd_word;
        end
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------

    // Sequencer state register; reset aborts any frame in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state: IDLE -> START on a pop, START -> WAIT after
    // one cycle, WAIT -> IDLE on tx_done_i. Disabling the block parks it.
    always_comb begin
        state_d = state_q;
        if (!fifo_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_d = START;
                    end
                end
                START: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (tx_done_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer outputs: the start request is the START state itself,
    // suppressed while the block is disabled.
    always_comb begin
        tx_start_o = 1'b0;
        if (fifo_en_i && (state_q == START)) begin
            tx_start_o = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_data_o        = tx_data_q;
    assign tx_ptr_addr_wr_o = wr_ptr_q;
    assign tx_ptr_addr_rd_o = rd_ptr_q;
    // Modulo subtraction gives the fill level directly, 0..DEPTH.
    assign count_o          = wr_ptr_q - rd_ptr_q;
    assign empty_o          = empty;
    assign full_o           = full;
    assign overflow_o       = overflow_q;

    assign dbg_o.state = state_q;
    assign dbg_o.push  = push;
    assign dbg_o.pop   = pop;
    assign dbg_o.drop  = drop;

    // ------------------------------------------------------------------
    // Embedded properties
    // ------------------------------------------------------------------

    // The fill level can never exceed the number of entries.
    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_o <= PTR_W'(DEPTH));

    // A start request never lasts more than one cycle.
    a_start_single: assert property (@(posedge clk_i) disable iff (rst_i)
        tx_start_o |=> !tx_start_o);

    // The transmit word cannot change while a frame is being issued.
    a_data_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q != IDLE) |-> (tx_data_d == tx_data_q));

endmodule : transmit_fifo_ctrl

// File: tb/tb_transmit_fifo_ctrl.sv
// Bench for transmit_fifo_ctrl: directed scenarios with literal
// expectations, plus a queue-based reference model compared against every
// output on every falling clock edge.
module tb_transmit_fifo_ctrl;
    import tx_fifo_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk;
    logic              rst_i;
    logic              fifo_en_i;
    logic              TXen_i;
    logic              wr_en_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              tx_busy_i;
    logic              tx_done_i;
    logic              tx_start_o;
    logic [DATA_W-1:0] tx_data_o;
    logic [PTR_W-1:0]  tx_ptr_addr_wr_o;
    logic [PTR_W-1:0]  tx_ptr_addr_rd_o;
    logic [PTR_W-1:0]  count_o;
    logic              empty_o;
    logic              full_o;
    logic              overflow_o;
    tx_dbg_t           dbg_o;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    transmit_fifo_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .fifo_en_i        (fifo_en_i),
        .TXen_i           (TXen_i),
        .wr_en_i          (wr_en_i),
        .wr_data_i        (wr_data_i),
        .tx_busy_i        (tx_busy_i),
        .tx_done_i        (tx_done_i),
        .tx_start_o       (tx_start_o),
        .tx_data_o        (tx_data_o),
        .tx_ptr_addr_wr_o (tx_ptr_addr_wr_o),
        .tx_ptr_addr_rd_o (tx_ptr_addr_rd_o),
        .count_o          (count_o),
        .empty_o          (empty_o),
        .full_o           (full_o),
        .overflow_o       (overflow_o),
        .dbg_o            (dbg_o)
    );

    // ------------------------------------------------------------------
    // Scoreboard primitive
    // ------------------------------------------------------------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of stored words, free-running pointer
    // counters, a sticky overflow bit and a frame phase
    // (0 = nothing issued, 1 = start cycle, 2 = frame in flight).
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] q_m [$];
    int                wr_m;
    int                rd_m;
    bit                ovf_m;
    int                phase_m;
    logic [DATA_W-1:0] data_m;

    task automatic model_reset();
        q_m.delete();
        wr_m    = 0;
        rd_m    = 0;
        ovf_m   = 1'b0;
        phase_m = 0;
        data_m  = '0;
    endtask

    task automatic model_step();
        bit was_full;
        bit take;
        if (!fifo_en_i) begin
            q_m.delete();
            wr_m    = 0;
            rd_m    = 0;
            ovf_m   = 1'b0;
            phase_m = 0;
            return;
        end
        was_full = (q_m.size() == DEPTH);
        take     = (phase_m == 0) && TXen_i && (q_m.size() != 0) && !tx_busy_i;
        if (wr_en_i && was_full) ovf_m = 1'b1;
        if (take) begin
            data_m  = q_m.pop_front();
            rd_m    = (rd_m + 1) % (2 ** PTR_W);
            phase_m = 1;
        end else if (phase_m == 1) begin
            phase_m = 2;
        end else if (phase_m == 2 && tx_done_i) begin
            phase_m = 0;
        end
        if (wr_en_i && !was_full) begin
            q_m.push_back(wr_data_i);
            wr_m = (wr_m + 1) % (2 ** PTR_W);
        end
    endtask

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) model_reset();
        else       model_step();
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        tx_state_e exp_state;
        exp_state = (phase_m == 0) ? IDLE : ((phase_m == 1) ? START : WAIT);
        check("count",    32'(count_o),          32'(q_m.size()));
        check("empty",    32'(empty_o),          32'(q_m.size() == 0));
        check("full",     32'(full_o),           32'(q_m.size() == DEPTH));
        check("wr_ptr",   32'(tx_ptr_addr_wr_o), 32'(wr_m));
        check("rd_ptr",   32'(tx_ptr_addr_rd_o), 32'(rd_m));
        check("overflow", 32'(overflow_o),       32'(ovf_m));
        check("tx_start", 32'(tx_start_o),       32'((phase_m == 1) && fifo_en_i));
        check("tx_data",  32'(tx_data_o),        32'(data_m));
        check("state",    32'(dbg_o.state),      32'(exp_state));
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 2 time units after each rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        wr_en_i   = 1'b1;
        wr_data_i = w;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (tx_start_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("start_timeout", 32'(0), 32'(1));
    endtask

    // Act as the serializer: take the word on start, stay busy, and
    // pulse tx_done_i 'gap' cycles after the start cycle (gap >= 2).
    task automatic serve_frame(input int gap, output logic [DATA_W-1:0] w);
        bit ok;
        wait_start(200, ok);
        w         = tx_data_o;
        tx_busy_i = 1'b1;
        repeat (gap - 1) tick();
        tx_busy_i = 1'b0;
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        logic [DATA_W-1:0] w;

        rst_i     = 1'b1;
        fifo_en_i = 1'b1;
        TXen_i    = 1'b0;
        wr_en_i   = 1'b0;
        wr_data_i = '0;
        tx_busy_i = 1'b0;
        tx_done_i = 1'b0;

        // Reset state.
        repeat (2) tick();
        check("rst_empty", 32'(empty_o), 32'(1));
        check("rst_full",  32'(full_o),  32'(0));
        check("rst_count", 32'(count_o), 32'(0));
        check("rst_start", 32'(tx_start_o), 32'(0));
        rst_i = 1'b0;
        tick();

        // Single word: start two cycles after the push edge.
        TXen_i = 1'b1;
        push_word(12'h101);
        check("lat_count1", 32'(count_o),    32'(1));
        check("lat_nostart", 32'(tx_start_o), 32'(0));
        tick();
        check("lat_start",  32'(tx_start_o), 32'(1));
        check("lat_data",   32'(tx_data_o),  32'(12'h101));
        check("lat_count0", 32'(count_o),    32'(0));
        tick();
        check("lat_single", 32'(tx_start_o), 32'(0));
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        check("lat_idle", 32'(dbg_o.state), 32'(IDLE));

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();

        // Fill with transmission blocked, then overflow.
        TXen_i = 1'b0;
        for (int i = 0; i < 16; i++) push_word(12'h100 + 12'(i));
        check("fill_full",  32'(full_o),           32'(1));
        check("fill_count", 32'(count_o),          32'(16));
        check("fill_wr",    32'(tx_ptr_addr_wr_o), 32'(5'h10));
        push_word(12'h1FF);
        check("ovf_set",   32'(overflow_o),       32'(1));
        check("ovf_wr",    32'(tx_ptr_addr_wr_o), 32'(5'h10));
        check("ovf_rd",    32'(tx_ptr_addr_rd_o), 32'(5'h00));
        check("ovf_count", 32'(count_o),          32'(16));

        // Drain 16 frames in order.
        TXen_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            serve_frame(10, w);
            check("drain_word", 32'(w), 32'(12'h100 + 12'(i)));
        end
        check("drain_empty", 32'(empty_o),          32'(1));
        check("drain_rd",    32'(tx_ptr_addr_rd_o), 32'(5'h10));

        // Simultaneous push and pop at count 3.
        TXen_i = 1'b0;
        push_word(12'h1A0);
        push_word(12'h1A1);
        push_word(12'h1A2);
        check("pp_pre_count", 32'(count_o), 32'(3));
        wr_en_i   = 1'b1;
        wr_data_i = 12'h1A3;
        TXen_i    = 1'b1;
        tick();
        wr_en_i = 1'b0;
        TXen_i  = 1'b0;
        check("pp_count", 32'(count_o),          32'(3));
        check("pp_wr",    32'(tx_ptr_addr_wr_o), 32'(5'h14));
        check("pp_rd",    32'(tx_ptr_addr_rd_o), 32'(5'h11));
        check("pp_start", 32'(tx_start_o),       32'(1));
        check("pp_data",  32'(tx_data_o),        32'(12'h1A0));
        tick();
        push_word(12'h1A4);
        check("wait_count", 32'(count_o),     32'(4));
        check("wait_held",  32'(dbg_o.state), 32'(WAIT));

        // Asynchronous reset in the middle of a frame.
        rst_i = 1'b1;
        #1;
        check("arst_count", 32'(count_o),    32'(0));
        check("arst_empty", 32'(empty_o),    32'(1));
        check("arst_start", 32'(tx_start_o), 32'(0));
        check("arst_data",  32'(tx_data_o),  32'(0));
        check("arst_state", 32'(dbg_o.state), 32'(IDLE));
        tick();
        rst_i  = 1'b0;
        TXen_i = 1'b1;
        repeat (5) begin
            tick();
            check("arst_nostart", 32'(tx_start_o), 32'(0));
        end
        push_word(12'h1B0);
        serve_frame(3, w);
        check("arst_new_word", 32'(w), 32'(12'h1B0));

        // Flush with words queued and overflow set.
        TXen_i = 1'b0;
        for (int i = 0; i < 16; i++) push_word(12'h200 + 12'(i));
        push_word(12'h2FF);
        check("fl_ovf", 32'(overflow_o), 32'(1));
        TXen_i = 1'b1;
        for (int i = 0; i < 11; i++) begin
            serve_frame(2, w);
            check("fl_word", 32'(w), 32'(12'h200 + 12'(i)));
        end
        TXen_i = 1'b0;
        check("fl_pre_count", 32'(count_o),    32'(5));
        check("fl_pre_ovf",   32'(overflow_o), 32'(1));
        fifo_en_i = 1'b0;
        wr_en_i   = 1'b1;
        wr_data_i = 12'h3FF;
        tick();
        wr_en_i = 1'b0;
        check("fl_count", 32'(count_o),     32'(0));
        check("fl_ovf0",  32'(overflow_o),  32'(0));
        check("fl_state", 32'(dbg_o.state), 32'(IDLE));
        check("fl_start", 32'(tx_start_o),  32'(0));
        check("fl_data",  32'(tx_data_o),   32'(12'h20A));
        check("fl_empty", 32'(empty_o),     32'(1));
        fifo_en_i = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: the directed run is only a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_transmit_fifo_ctrl
